// File: rtl/u712_sdram_access_arbiter_if.sv
// Handshake bundle between the chip-RAM requesters, the SDRAM sequencer and the access arbiter.
// The master side is the arbiter: it consumes requests and completion, and drives grants and the start pulse.
interface u712_sdram_access_arbiter_if;
  logic DMA_REQ;
  logic CPU_REQ;
  logic SEQ_DONE;
  logic DMA_GNT;
  logic CPU_GNT;
  logic REF_GNT;
  logic CYCLE_START;

  modport master (
    input  DMA_REQ,
    input  CPU_REQ,
    input  SEQ_DONE,
    output DMA_GNT,
    output CPU_GNT,
    output REF_GNT,
    output CYCLE_START
  );

  modport slave (
    output DMA_REQ,
    output CPU_REQ,
    output SEQ_DONE,
    input  DMA_GNT,
    input  CPU_GNT,
    input  REF_GNT,
    input  CYCLE_START
  );
endinterface

// File: rtl/u712_sdram_access_arbiter.sv
// Chip-RAM SDRAM access arbiter: schedules Agnus DMA, CPU and auto-refresh onto the sequencer,
// counting owed refreshes from the C1 timebase and letting refresh yield until it is urgent.
module u712_sdram_access_arbiter #(
  parameter int REFRESH_INTERVAL = 27,
  parameter int MAX_PENDING      = 8,
  parameter int URGENT_LEVEL     = 4,
  parameter int CPU_STARVE_LIMIT = 6
) (
  input  logic                        CLK80,
  input  logic                        REFRESH_RST,
  input  logic                        C1,
  input  logic                        SDRAM_READY,
  u712_sdram_access_arbiter_if.master bus,
  output logic [3:0]                  REF_PENDING,
  output logic                        REF_OVERFLOW
);

  localparam int TICK_W   = $clog2(REFRESH_INTERVAL);
  localparam int STREAK_W = $clog2(CPU_STARVE_LIMIT + 1);

  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(REFRESH_INTERVAL - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(CPU_STARVE_LIMIT);
  localparam logic [3:0]          PEND_MAX    = 4'(MAX_PENDING);
  localparam logic [3:0]          PEND_URGENT = 4'(URGENT_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DMA,
    SEL_CPU,
    SEL_REF
  } sel_t;

  state_t              state_reg, state_next;
  sel_t                owner_reg, owner_next;
  sel_t                sel;
  logic                cycle_start_reg, cycle_start_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic [3:0]          pending_reg, pending_next;
  logic                overflow_reg, overflow_next;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic                c1_meta_reg, c1_sync_reg, c1_prev_reg;
  logic                tick;
  logic                wrap;
  logic                ref_start;

  // C1 is asynchronous to CLK80: two-flop synchroniser followed by an edge detector
  always_ff @(negedge CLK80 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      c1_meta_reg <= 1'b0;
      c1_sync_reg <= 1'b0;
      c1_prev_reg <= 1'b0;
    end else begin
      c1_meta_reg <= C1;
      c1_sync_reg <= c1_meta_reg;
      c1_prev_reg <= c1_sync_reg;
    end
  end

  assign tick = c1_sync_reg & ~c1_prev_reg;
  assign wrap = tick && (tick_cnt_reg == TICK_LAST);

  always_ff @(negedge CLK80 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
    end
  end

  // A refresh is paid off in the cycle its start pulse is on the bus
  assign ref_start = cycle_start_reg && (owner_reg == SEL_REF);

  always_comb begin
    pending_next  = pending_reg;
    overflow_next = overflow_reg;
    if (wrap && !ref_start) begin
      if (pending_reg == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending_reg + 4'd1;
      end
    end else if (!wrap && ref_start && (pending_reg != 4'd0)) begin
      pending_next = pending_reg - 4'd1;
    end
  end

  always_comb begin
    sel = SEL_NONE;
    if (pending_reg >= PEND_URGENT) begin
      sel = SEL_REF;
    end else if (bus.CPU_REQ && (streak_reg >= STREAK_MAX)) begin
      sel = SEL_CPU;
    end else if (bus.DMA_REQ) begin
      sel = SEL_DMA;
    end else if (bus.CPU_REQ) begin
      sel = SEL_CPU;
    end else if (pending_reg != 4'd0) begin
      sel = SEL_REF;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    cycle_start_next = 1'b0;
    streak_next      = streak_reg;
    case (state_reg)
      ST_IDLE: begin
        owner_next = SEL_NONE;
        if (SDRAM_READY && (sel != SEL_NONE)) begin
          state_next       = ST_GRANT;
          owner_next       = sel;
          cycle_start_next = 1'b1;
          if (sel == SEL_DMA) begin
            if (streak_reg != STREAK_MAX) begin
              streak_next = streak_reg + 1'b1;
            end
          end else if (sel == SEL_CPU) begin
            streak_next = '0;
          end
        end
      end
      ST_GRANT: begin
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.SEQ_DONE) begin
          state_next = ST_IDLE;
          owner_next = SEL_NONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        owner_next = SEL_NONE;
      end
    endcase
  end

  always_ff @(negedge CLK80 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= SEL_NONE;
      cycle_start_reg <= 1'b0;
      streak_reg      <= '0;
      pending_reg     <= 4'd0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      cycle_start_reg <= cycle_start_next;
      streak_reg      <= streak_next;
      pending_reg     <= pending_next;
      overflow_reg    <= overflow_next;
    end
  end

  // Grants decode from a single owner register, so they are one-hot or all-zero by construction
  assign bus.DMA_GNT     = (owner_reg == SEL_DMA);
  assign bus.CPU_GNT     = (owner_reg == SEL_CPU);
  assign bus.REF_GNT     = (owner_reg == SEL_REF);
  assign bus.CYCLE_START = cycle_start_reg;
  assign REF_PENDING     = pending_reg;
  assign REF_OVERFLOW    = overflow_reg;

endmodule

// File: tb/tb_u712_sdram_access_arbiter.sv
// Self-checking bench for the SDRAM access arbiter: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of owed refreshes and ownership.
`timescale 1ns/1ps
module tb_u712_sdram_access_arbiter;
  localparam int INTERVAL = 27;
  localparam int MAXP     = 8;
  localparam int URGENT   = 4;
  localparam int STARVE   = 6;
  localparam int O_NONE = 0, O_DMA = 1, O_CPU = 2, O_REF = 3;

  logic       CLK80       = 1'b0;
  logic       REFRESH_RST = 1'b1;
  logic       C1          = 1'b0;
  logic       SDRAM_READY = 1'b0;
  logic [3:0] REF_PENDING;
  logic       REF_OVERFLOW;

  u712_sdram_access_arbiter_if bus();

  u712_sdram_access_arbiter #(
    .REFRESH_INTERVAL(INTERVAL),
    .MAX_PENDING(MAXP),
    .URGENT_LEVEL(URGENT),
    .CPU_STARVE_LIMIT(STARVE)
  ) dut (
    .CLK80(CLK80),
    .REFRESH_RST(REFRESH_RST),
    .C1(C1),
    .SDRAM_READY(SDRAM_READY),
    .bus(bus),
    .REF_PENDING(REF_PENDING),
    .REF_OVERFLOW(REF_OVERFLOW)
  );

  always #5 CLK80 = ~CLK80;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int seq_mode = 0;

  task automatic check_value(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] gnt_of(int o);
    case (o)
      O_DMA:   return 3'b100;
      O_CPU:   return 3'b010;
      O_REF:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic string name_of(int o);
    case (o)
      O_DMA:   return "DMA";
      O_CPU:   return "CPU";
      O_REF:   return "REFRESH";
      default: return "none";
    endcase
  endfunction

  // Behavioural model: who owns the sequencer, whether this is its first cycle, and what is owed
  int       m_owner  = O_NONE;
  bit       m_cs     = 1'b0;
  int       m_owed   = 0;
  bit       m_ovf    = 1'b0;
  int       m_ticks  = 0;
  int       m_streak = 0;
  bit [3:0] m_c1     = '0;

  always @(negedge CLK80 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      m_owner  = O_NONE;
      m_cs     = 1'b0;
      m_owed   = 0;
      m_ovf    = 1'b0;
      m_ticks  = 0;
      m_streak = 0;
      m_c1     = '0;
    end else begin
      bit tick;
      bit wrap;
      bit ref_start;
      int owed_then;
      int pick;
      owed_then = m_owed;
      // a C1 rise sampled two edges ago becomes a tick now
      tick = m_c1[1] && !m_c1[2];
      wrap = tick && (m_ticks == INTERVAL - 1);
      if (tick) m_ticks = (m_ticks + 1) % INTERVAL;
      ref_start = m_cs && (m_owner == O_REF);
      m_owed = m_owed + (wrap ? 1 : 0) - (ref_start ? 1 : 0);
      if (m_owed > MAXP) begin
        m_owed = MAXP;
        m_ovf  = 1'b1;
      end
      if (m_owner == O_NONE) begin
        pick = O_NONE;
        if (SDRAM_READY) begin
          if (owed_then >= URGENT)                       pick = O_REF;
          else if (bus.CPU_REQ && m_streak >= STARVE)    pick = O_CPU;
          else if (bus.DMA_REQ)                          pick = O_DMA;
          else if (bus.CPU_REQ)                          pick = O_CPU;
          else if (owed_then > 0)                        pick = O_REF;
        end
        if (pick != O_NONE) begin
          m_owner = pick;
          m_cs    = 1'b1;
          if (pick == O_DMA)      m_streak = (m_streak < STARVE) ? m_streak + 1 : STARVE;
          else if (pick == O_CPU) m_streak = 0;
          $display("[%0t] grant %s owed=%0d streak=%0d", $time, name_of(pick), owed_then, m_streak);
        end
      end else if (m_cs) begin
        m_cs = 1'b0;
      end else if (bus.SEQ_DONE) begin
        m_owner = O_NONE;
      end
      m_c1 = {m_c1[2:0], C1};
    end
  end

  always @(posedge CLK80) begin
    if (chk_en && !REFRESH_RST) begin
      check_value("grants", 32'(gnt_of(m_owner)) ^ 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT}) ^ 32'(gnt_of(m_owner)),
                  32'(gnt_of(m_owner)));
      check_value("cycle_start", 32'(bus.CYCLE_START), 32'(m_cs));
      check_value("ref_pending", 32'(REF_PENDING), 32'(m_owed));
      check_value("ref_overflow", 32'(REF_OVERFLOW), 32'(m_ovf));
    end
  end

  // Sequencer stand-in: finish on first BUSY cycle, random pulses, or never finish
  always @(posedge CLK80) begin
    case (seq_mode)
      0:       bus.SEQ_DONE = (m_owner != O_NONE) && !m_cs;
      1:       bus.SEQ_DONE = ($urandom_range(0, 2) == 0);
      default: bus.SEQ_DONE = 1'b0;
    endcase
  end

  task automatic c1_edges(int n);
    repeat (n) begin
      @(posedge CLK80); C1 = 1'b1;
      repeat (3) @(posedge CLK80);
      C1 = 1'b0;
      repeat (2) @(posedge CLK80);
    end
  endtask

  task automatic wait_quiet(string tag, int budget);
    int n = 0;
    repeat (4) @(posedge CLK80);
    while ((REF_PENDING != 4'd0 || {bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT} != 3'b000) && n < budget) begin
      @(posedge CLK80);
      n++;
    end
    check_value(tag, 32'(REF_PENDING), 32'd0);
  endtask

  logic [2:0] seen[$];
  logic [2:0] exp_seq[8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100};

  initial begin
    bit found;
    int need;
    bus.DMA_REQ  = 1'b0;
    bus.CPU_REQ  = 1'b0;
    bus.SEQ_DONE = 1'b0;

    // reset state
    repeat (3) @(posedge CLK80);
    #1;
    check_value("reset_grants", 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT}), 32'd0);
    check_value("reset_cycle_start", 32'(bus.CYCLE_START), 32'd0);
    check_value("reset_pending", 32'(REF_PENDING), 32'd0);
    check_value("reset_overflow", 32'(REF_OVERFLOW), 32'd0);
    @(posedge CLK80);
    REFRESH_RST = 1'b0;
    SDRAM_READY = 1'b1;
    chk_en      = 1'b1;

    // single refresh after one full interval
    c1_edges(INTERVAL - 1);
    @(posedge CLK80); C1 = 1'b1;
    repeat (3) @(posedge CLK80);
    check_value("t1_pending_up", 32'(REF_PENDING), 32'd1);
    check_value("t1_no_grant_yet", 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT}), 32'd0);
    @(posedge CLK80);
    C1 = 1'b0;
    check_value("t1_ref_grant", 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT, bus.CYCLE_START}), 32'b0011);
    @(posedge CLK80);
    check_value("t1_pending_paid", 32'(REF_PENDING), 32'd0);
    repeat (4) @(posedge CLK80);
    check_value("t1_back_idle", 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT}), 32'd0);

    // CPU starvation guard against continuous DMA
    @(posedge CLK80);
    bus.DMA_REQ = 1'b1;
    bus.CPU_REQ = 1'b1;
    for (int i = 0; i < 200 && seen.size() < 8; i++) begin
      @(posedge CLK80);
      if (bus.CYCLE_START) seen.push_back({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT});
    end
    check_value("t2_grant_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check_value($sformatf("t2_grant_%0d", i), 32'(seen[i]), 32'(exp_seq[i]));
    bus.DMA_REQ = 1'b0;
    bus.CPU_REQ = 1'b0;
    repeat (6) @(posedge CLK80);

    // refresh yields to DMA until urgent
    bus.DMA_REQ = 1'b1;
    c1_edges(URGENT * INTERVAL - 1);
    check_value("t3_pending_3", 32'(REF_PENDING), 32'd3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge CLK80);
      if (bus.CYCLE_START) begin
        found = 1'b1;
        check_value("t3_dma_wins_at_3", 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT}), 32'b100);
      end
    end
    check_value("t3_dma_grant_seen", 32'(found), 32'd1);
    @(posedge CLK80); C1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge CLK80);
      if (i == 2) C1 = 1'b0;
      if (bus.CYCLE_START && bus.REF_GNT) begin
        found = 1'b1;
        check_value("t3_urgent_pending", 32'(REF_PENDING), 32'd4);
      end
    end
    C1 = 1'b0;
    check_value("t3_urgent_refresh_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge CLK80);
      if (bus.CYCLE_START) begin
        found = 1'b1;
        check_value("t3_dma_after_refresh", 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT}), 32'b100);
      end
    end
    check_value("t3_dma_after_seen", 32'(found), 32'd1);
    bus.DMA_REQ = 1'b0;
    wait_quiet("t3_drained", 200);

    // interval wrap coinciding with a refresh start leaves the count unchanged
    SDRAM_READY = 1'b0;
    need = (INTERVAL - m_ticks) + INTERVAL + (INTERVAL - 1);
    c1_edges(need);
    check_value("t5_pending_before", 32'(REF_PENDING), 32'd2);
    @(posedge CLK80); C1 = 1'b1;
    @(posedge CLK80); SDRAM_READY = 1'b1;
    @(posedge CLK80);
    check_value("t5_ref_start", 32'({bus.REF_GNT, bus.CYCLE_START}), 32'b11);
    @(posedge CLK80);
    C1 = 1'b0;
    check_value("t5_pending_same", 32'(REF_PENDING), 32'd2);
    wait_quiet("t5_drained", 200);

    // randomized traffic
    seq_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge CLK80);
      if ($urandom_range(0, 3) == 0) bus.DMA_REQ = ~bus.DMA_REQ;
      if ($urandom_range(0, 3) == 0) bus.CPU_REQ = ~bus.CPU_REQ;
      if ($urandom_range(0, 2) == 0) C1 = ~C1;
      if (SDRAM_READY && $urandom_range(0, 59) == 0) SDRAM_READY = 1'b0;
      else if (!SDRAM_READY && $urandom_range(0, 7) == 0) SDRAM_READY = 1'b1;
    end
    C1          = 1'b0;
    bus.DMA_REQ = 1'b0;
    bus.CPU_REQ = 1'b0;
    SDRAM_READY = 1'b1;
    seq_mode    = 0;
    wait_quiet("rand_drained", 400);

    // asynchronous reset in the middle of a DMA cycle
    SDRAM_READY = 1'b0;
    c1_edges(INTERVAL - m_ticks);
    check_value("t6_pending_1", 32'(REF_PENDING), 32'd1);
    seq_mode    = 2;
    bus.DMA_REQ = 1'b1;
    SDRAM_READY = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge CLK80);
      if (bus.DMA_GNT && !bus.CYCLE_START) found = 1'b1;
    end
    check_value("t6_dma_busy_seen", 32'(found), 32'd1);
    #2 REFRESH_RST = 1'b1;
    #1;
    check_value("t6_rst_dma_gnt", 32'(bus.DMA_GNT), 32'd0);
    check_value("t6_rst_pending", 32'(REF_PENDING), 32'd0);
    repeat (2) @(posedge CLK80);
    REFRESH_RST = 1'b0;
    seq_mode    = 0;
    @(posedge CLK80);
    check_value("t6_regrant", 32'({bus.DMA_GNT, bus.CYCLE_START}), 32'b11);
    bus.DMA_REQ = 1'b0;
    repeat (6) @(posedge CLK80);

    // saturation of owed refreshes while the sequencer is not ready
    SDRAM_READY = 1'b0;
    c1_edges(MAXP * INTERVAL);
    check_value("t4_pending_max", 32'(REF_PENDING), 32'(MAXP));
    check_value("t4_no_overflow_yet", 32'(REF_OVERFLOW), 32'd0);
    c1_edges(INTERVAL);
    check_value("t4_pending_sat", 32'(REF_PENDING), 32'(MAXP));
    check_value("t4_overflow", 32'(REF_OVERFLOW), 32'd1);
    check_value("t4_no_grants", 32'({bus.DMA_GNT, bus.CPU_GNT, bus.REF_GNT}), 32'd0);
    repeat (4) @(posedge CLK80);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
    $fatal(1, "watchdog timeout");
  end

endmodule
